// File: rtl/iobus_arb_pkg.sv
// Shared types and encodings for the two-master iobus arbiter.
package iobus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    localparam logic [1:0] WE_RD = 2'b00;
    localparam logic [1:0] WE_B  = 2'b01;
    localparam logic [1:0] WE_H  = 2'b10;
    localparam logic [1:0] WE_W  = 2'b11;

    typedef struct packed {
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        lock;
    } mst_req_t;

    function automatic logic is_write(input logic [1:0] we);
        return we != WE_RD;
    endfunction

endpackage

// File: rtl/iobus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker with an optional hold on the last winner.
module rr_pick2
    import iobus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       lock_hold,
    output logic       valid,
    output logic       gnt
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (lock_hold && req[last_gnt]) begin
            gnt = last_gnt;
        end else if (req == 2'b11) begin
            gnt = ~last_gnt;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-master round-robin arbiter in front of the single-port iobus.
// Define ARB_LOCK_EN to honour m*_lock (bounded back-to-back grants, LOCK_MAX).
//
// state  | meaning
// IDLE   | bus parked at IDLE_ADDR, pick a winner when any req is high
// ACCESS | winner drives the bus, write commits and read data is captured at the closing edge
// ACK    | one-cycle ack to the winner, requests ignored
module iobus_arbiter
    import iobus_arb_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
    parameter int          LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [1:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [1:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic [1:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_data
);

    arb_state_t  state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] m0_rd_q, m0_rd_d;
    logic [31:0] m1_rd_q, m1_rd_d;

    mst_req_t    m0_bundle, m1_bundle, sel;
    logic        pick_valid, pick_gnt, lock_hold;

    assign m0_bundle = '{we: m0_we, addr: m0_addr, wd: m0_wd, lock: m0_lock};
    assign m1_bundle = '{we: m1_we, addr: m1_addr, wd: m1_wd, lock: m1_lock};
    assign sel       = gnt_q ? m1_bundle : m0_bundle;

    rr_pick2 u_pick (
        .req       ({m1_req, m0_req}),
        .last_gnt  (last_gnt_q),
        .lock_hold (lock_hold),
        .valid     (pick_valid),
        .gnt       (pick_gnt)
    );

`ifdef ARB_LOCK_EN
    localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_arm_q, lock_arm_d;

    assign lock_hold = lock_arm_q;

    // The arm flag remembers that the access just finished was locked and still within budget.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_arm_d = lock_arm_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    lock_arm_d = 1'b0;
                    if (lock_arm_q && (pick_gnt == last_gnt_q)) begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
            end
            ACCESS: begin
                lock_arm_d = sel.lock && (lock_cnt_q < LCW'(LOCK_MAX - 1));
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_cnt_q <= '0;
            lock_arm_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_arm_q <= lock_arm_d;
        end
    end
`else
    logic unused_lock;

    assign lock_hold   = 1'b0;
    assign unused_lock = sel.lock ^ (^LOCK_MAX);
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ack_d      = 2'b00;
        m0_rd_d    = m0_rd_q;
        m1_rd_d    = m1_rd_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick_gnt;
                    last_gnt_d = pick_gnt;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (gnt_q) begin
                    m1_rd_d = bus_data;
                end else begin
                    m0_rd_d = bus_data;
                end
                ack_d   = gnt_q ? 2'b10 : 2'b01;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack_q      <= 2'b00;
            m0_rd_q    <= '0;
            m1_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ack_q      <= ack_d;
            m0_rd_q    <= m0_rd_d;
            m1_rd_q    <= m1_rd_d;
        end
    end

    // Parked address keeps side-effecting reads (UART RX status) quiet between accesses.
    always_comb begin
        bus_we   = WE_RD;
        bus_addr = IDLE_ADDR;
        bus_wd   = '0;
        if (state_q == ACCESS) begin
            bus_we   = sel.we;
            bus_addr = sel.addr;
            bus_wd   = sel.wd;
        end
        if (!reset) begin
            bus_we = WE_RD;
        end
    end

    // Gating with reset suppresses an ack whose cycle coincides with reset.
    assign m0_ack = ack_q[0] & reset;
    assign m1_ack = ack_q[1] & reset;
    assign m0_rd  = m0_rd_q;
    assign m1_rd  = m1_rd_q;

endmodule
